metronome_engine: RTL and testbench
===================================

// Module: metronome_engine
// PURPOSE
// Parametrised metronome core replacing the fixed single-tone beat generator. Generates beats
//   from a BPM value using a phase accumulator, so a BPM change never restarts the beat.
// Groups beats into bars with a distinct accent tone on beat 0. Drives the piezo bell directly.
// Exports beat strobes and beat index for the seven-segment and LED logic.
// PARAMETERS
// CLK_HZ     100_000_000  system clock frequency in Hz
// BPM_W      8            width of bpm input
// BPM_MIN    30           lower clamp on bpm
// BPM_MAX    250          upper clamp on bpm (must fit in BPM_W)
// BAR_W      3            width of beats_per_bar / beat_idx
// TONE_HZ    1000         normal-beat tone frequency; CLK_HZ/(2*TONE_HZ) must be integer
// ACCENT_HZ  2000         downbeat tone frequency; same integer rule
// BEEP_MS    50           tone length per beat; must be shorter than the beat period at BPM_MAX
// PORTS
// clk            in   1      system clock
// rst            in   1      asynchronous, active-high reset
// play           in   1      level: 1 = run, 0 = stop (debounced/toggled upstream)
// bpm            in   BPM_W  beats per minute, sampled every cycle, clamped
// beats_per_bar  in   BAR_W  0 = no accent; 1 = every beat accented; N = accent every N beats
// bell           out  1      square-wave tone to buzzer
// beat_pulse     out  1      one-cycle strobe at the start of each beat
// downbeat       out  1      one-cycle strobe, coincident with beat_pulse, on accented beats
// beat_idx       out  BAR_W  index of the current beat in the bar, 0..beats_per_bar-1
// running        out  1      1 while in RUN or BEEP
// BEHAVIOUR
// - Reset (async, rst=1): all outputs 0; acc=0, state IDLE, tone counters 0.
// - PERIOD = 60*CLK_HZ. bpm_c = clamp(bpm, BPM_MIN, BPM_MAX). Accumulator acc is wide enough
//   for PERIOD+BPM_MAX.
// - FSM states: IDLE, RUN (silent), BEEP (tone active).
// - IDLE & play=1 at edge N -> BEEP. At cycle N+1: beat_pulse=1, beat_idx=0, acc=0, running=1.
//   This first beat is downbeat if beats_per_bar!=0.
// - RUN/BEEP, each cycle: if acc+bpm_c >= PERIOD then acc<=acc+bpm_c-PERIOD and fire a beat.
//   Otherwise acc<=acc+bpm_c. Exact beat spacing is PERIOD/bpm_c cycles (fractional carry kept).
// - Beat fire: beat_pulse=1 for one cycle and beat_idx advances.
//   Wrap to 0 when idx+1 >= beats_per_bar (also when beats_per_bar shrank below idx+1).
//   beats_per_bar 0 or 1 keeps idx at 0.
// - Downbeat: downbeat=1 when new idx==0 and beats_per_bar!=0. Tone half-period is then
//   CLK_HZ/(2*ACCENT_HZ), otherwise CLK_HZ/(2*TONE_HZ).
// - Beep: state BEEP for BEEP_CYC=CLK_HZ*BEEP_MS/1000 cycles. bell starts high on the beat
//   cycle and toggles every half-period; at expiry bell=0 and the FSM moves to RUN.
// - A beat firing during BEEP (misconfigured params) restarts the beep with the new tone,
//   phase high.
// - play=0 in RUN/BEEP: next cycle -> IDLE, bell=0, running=0, acc=0, beat_idx=0, no strobes.
//   The current tone is truncated.
// - bpm change mid-run: new bpm_c applies from the next accumulation; the beat in progress
//   keeps its accumulated phase.
// - rst mid-beep: bell drops asynchronously to 0.
// TESTING  (CLK_HZ=6000, TONE_HZ=500, ACCENT_HZ=1000, BEEP_MS=50 -> PERIOD=360000,
//   half-periods 6/3, BEEP_CYC=300)
// 1 bpm=120, bpb=4, play 0->1 at edge N -> beat_pulse at N+1, N+3001, N+6001, ...
//   beat_idx 0,1,2,3,0; downbeat only at idx 0.
// 2 Tone: accent beat bell toggles every 3 cycles for 300 cycles; normal beat every 6 cycles;
//   bell=0 after 300 cycles.
// 3 Clamp: bpm=10 -> spacing 12000 cycles (BPM_MIN 30); bpm=255 -> spacing 1440 cycles (BPM_MAX 250).
// 4 Fraction: bpm=7 clamped; bpm=97 -> 97 beats over exactly 360000 cycles, every spacing 3711 or 3712.
// 5 bpb 4->2 while beat_idx=3 -> next beat idx 0 with downbeat; bpb=0 -> no downbeat ever,
//   tone 6-cycle.
// 6 play=0 mid-beep -> bell=0, running=0, beat_idx=0 next cycle. rst pulse during BEEP ->
//   all outputs 0 immediately; replay starts at idx 0.

Source files
------------

// File: rtl/metronome_engine.sv
// rtl/metronome_engine.sv - phase-accumulator metronome with bar grouping, accented downbeat and piezo tone
// A BPM change only alters the accumulation rate, so the beat in progress keeps its phase.
module metronome_engine #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BPM_W     = 8,
  parameter int unsigned BPM_MIN   = 30,
  parameter int unsigned BPM_MAX   = 250,
  parameter int unsigned BAR_W     = 3,
  parameter int unsigned TONE_HZ   = 1000,
  parameter int unsigned ACCENT_HZ = 2000,
  parameter int unsigned BEEP_MS   = 50
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             play_i,
  input  logic [BPM_W-1:0] bpm_i,
  input  logic [BAR_W-1:0] beats_per_bar_i,
  output logic             bell_o,
  output logic             beat_pulse_o,
  output logic             downbeat_o,
  output logic [BAR_W-1:0] beat_idx_o,
  output logic             running_o
);

  localparam longint unsigned PERIOD      = 64'(CLK_HZ) * 64'd60;
  localparam int unsigned     ACC_W       = $clog2(PERIOD + 64'(BPM_MAX) + 64'd1);
  localparam longint unsigned BEEP_CYC    = 64'(CLK_HZ) * 64'(BEEP_MS) / 64'd1000;
  localparam int unsigned     BEEP_W      = $clog2(BEEP_CYC + 64'd1);
  localparam int unsigned     TONE_HALF   = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned     ACCENT_HALF = CLK_HZ / (2 * ACCENT_HZ);
  localparam int unsigned     HALF_MAX    = (TONE_HALF > ACCENT_HALF) ? TONE_HALF : ACCENT_HALF;
  localparam int unsigned     HALF_W      = $clog2(HALF_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_BEEP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [BAR_W-1:0]    idx_q, idx_d;
  logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
  logic [HALF_W-1:0]   half_cnt_q, half_cnt_d;
  logic                accent_q, accent_d;
  logic                bell_q, bell_d;
  logic                pulse_q, pulse_d;
  logic                down_q, down_d;

  logic [BPM_W-1:0]    bpm_c;
  logic [ACC_W-1:0]    acc_sum;
  logic                fire;
  logic [BAR_W:0]      idx_inc;
  logic [BAR_W-1:0]    idx_next;
  logic                bar_on;
  logic [HALF_W-1:0]   half_lim;

  always_comb begin
    if (bpm_i < BPM_W'(BPM_MIN)) begin
      bpm_c = BPM_W'(BPM_MIN);
    end else if (bpm_i > BPM_W'(BPM_MAX)) begin
      bpm_c = BPM_W'(BPM_MAX);
    end else begin
      bpm_c = bpm_i;
    end
  end

  assign acc_sum  = acc_q + ACC_W'(bpm_c);
  assign fire     = (acc_sum >= ACC_W'(PERIOD));
  assign bar_on   = (beats_per_bar_i != '0);
  // Comparing against the live bar length also wraps when the bar shrank under the index.
  assign idx_inc  = {1'b0, idx_q} + (BAR_W + 1)'(1);
  assign idx_next = (idx_inc >= {1'b0, beats_per_bar_i}) ? '0 : idx_inc[BAR_W-1:0];
  assign half_lim = accent_q ? HALF_W'(ACCENT_HALF - 1) : HALF_W'(TONE_HALF - 1);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    beep_cnt_d = beep_cnt_q;
    half_cnt_d = half_cnt_q;
    accent_d   = accent_q;
    bell_d     = bell_q;
    pulse_d    = 1'b0;
    down_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (play_i) begin
          state_d    = S_BEEP;
          acc_d      = '0;
          idx_d      = '0;
          pulse_d    = 1'b1;
          down_d     = bar_on;
          accent_d   = bar_on;
          bell_d     = 1'b1;
          beep_cnt_d = '0;
          half_cnt_d = '0;
        end
      end
      default: begin
        if (!play_i) begin
          state_d    = S_IDLE;
          acc_d      = '0;
          idx_d      = '0;
          accent_d   = 1'b0;
          bell_d     = 1'b0;
          beep_cnt_d = '0;
          half_cnt_d = '0;
        end else if (fire) begin
          // A beat always (re)starts the tone with phase high, even mid-beep.
          state_d    = S_BEEP;
          acc_d      = acc_sum - ACC_W'(PERIOD);
          idx_d      = idx_next;
          pulse_d    = 1'b1;
          down_d     = (idx_next == '0) && bar_on;
          accent_d   = (idx_next == '0) && bar_on;
          bell_d     = 1'b1;
          beep_cnt_d = '0;
          half_cnt_d = '0;
        end else begin
          acc_d = acc_sum;
          if (state_q == S_BEEP) begin
            if (beep_cnt_q == BEEP_W'(BEEP_CYC - 64'd1)) begin
              state_d    = S_RUN;
              bell_d     = 1'b0;
              beep_cnt_d = '0;
              half_cnt_d = '0;
            end else begin
              beep_cnt_d = beep_cnt_q + BEEP_W'(1);
              if (half_cnt_q == half_lim) begin
                half_cnt_d = '0;
                bell_d     = ~bell_q;
              end else begin
                half_cnt_d = half_cnt_q + HALF_W'(1);
              end
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      beep_cnt_q <= '0;
      half_cnt_q <= '0;
      accent_q   <= 1'b0;
      bell_q     <= 1'b0;
      pulse_q    <= 1'b0;
      down_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      beep_cnt_q <= beep_cnt_d;
      half_cnt_q <= half_cnt_d;
      accent_q   <= accent_d;
      bell_q     <= bell_d;
      pulse_q    <= pulse_d;
      down_q     <= down_d;
    end
  end

  assign bell_o       = bell_q;
  assign beat_pulse_o = pulse_q;
  assign downbeat_o   = down_q;
  assign beat_idx_o   = idx_q;
  assign running_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_metronome_engine.sv
// tb/tb_metronome_engine.sv - self-checking bench for metronome_engine
// Small clock (6 kHz) so a 120 BPM beat spans 3000 cycles; tone half-periods 6 and 3, beep 300 cycles.
module tb_metronome_engine;

  localparam longint P = 360000;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       play_i = 1'b0;
  logic [7:0] bpm_i = 8'd120;
  logic [2:0] bpb_i = 3'd0;
  logic       bell_o, beat_pulse_o, downbeat_o, running_o;
  logic [2:0] beat_idx_o;

  metronome_engine #(
    .CLK_HZ(6000), .BPM_W(8), .BPM_MIN(30), .BPM_MAX(250), .BAR_W(3),
    .TONE_HZ(500), .ACCENT_HZ(1000), .BEEP_MS(50)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .play_i(play_i), .bpm_i(bpm_i),
    .beats_per_bar_i(bpb_i), .bell_o(bell_o), .beat_pulse_o(beat_pulse_o),
    .downbeat_o(downbeat_o), .beat_idx_o(beat_idx_o), .running_o(running_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int bpm; int bpb; int spacing; bit down1; int idx2; bit down2; int half1; int half2;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i  = 1'b1;
    play_i = 1'b0;
    tick();
    tick();
    check("reset_outputs", {bell_o, beat_pulse_o, downbeat_o, beat_idx_o, running_o}, 0);
    rst_i = 1'b0;
    tick();
  endtask

  task automatic wait_beat(input string name, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!beat_pulse_o && n < limit);
    if (!beat_pulse_o) check({name, "_timeout"}, 0, 1);
  endtask

  // Called on the beat cycle; walks 301 cycles and counts as one comparison.
  task automatic check_tone(input string name, input int half);
    bit ok = 1'b1;
    int bad_d = 0;
    logic got_b = 1'b0, exp_b, want_b = 1'b0;
    for (int d = 0; d <= 300; d++) begin
      if (d > 0) tick();
      exp_b = (d < 300) && (((d / half) % 2) == 0);
      if (bell_o !== exp_b || running_o !== 1'b1 || (d > 0 && beat_pulse_o !== 1'b0)) begin
        if (ok) begin
          bad_d  = d;
          got_b  = bell_o;
          want_b = exp_b;
        end
        ok = 1'b0;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s offset=%0d bell=%0b expected=%0b (or strobe/running wrong)", name, bad_d, got_b, want_b);
    end
  endtask

  function automatic int clampb(input int b);
    return (b < 30) ? 30 : ((b > 250) ? 250 : b);
  endfunction

  initial begin
    int n;
    int rerr;
    longint phase;
    int k, m_idx, last, half, bc, bpb;
    bit m_run, m_pulse, m_down, m_bell;
    int r;

    vecs[0] = '{bpm:120, bpb:4, spacing:3000,  down1:1, idx2:1, down2:0, half1:3, half2:6};
    vecs[1] = '{bpm:10,  bpb:0, spacing:12000, down1:0, idx2:0, down2:0, half1:6, half2:6};
    vecs[2] = '{bpm:255, bpb:1, spacing:1440,  down1:1, idx2:0, down2:1, half1:3, half2:3};
    vecs[3] = '{bpm:250, bpb:2, spacing:1440,  down1:1, idx2:1, down2:0, half1:3, half2:6};
    vecs[4] = '{bpm:200, bpb:7, spacing:1800,  down1:1, idx2:1, down2:0, half1:3, half2:6};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      bpm_i  = 8'(vecs[v].bpm);
      bpb_i  = 3'(vecs[v].bpb);
      play_i = 1'b1;
      tick();
      check("start_strobe", {beat_pulse_o, downbeat_o, beat_idx_o, running_o},
            {1'b1, vecs[v].down1, 3'd0, 1'b1});
      check_tone("tone_first", vecs[v].half1);
      wait_beat("vec_beat", 13000, n);
      check("spacing", 300 + n, vecs[v].spacing);
      check("second_beat", {downbeat_o, beat_idx_o}, {vecs[v].down2, 3'(vecs[v].idx2)});
      check_tone("tone_second", vecs[v].half2);
      play_i = 1'b0;
      tick();
      check("stop", {bell_o, beat_pulse_o, downbeat_o, beat_idx_o, running_o}, 0);
    end

    // Bar length shrinks while the index sits above it, then accents are disabled.
    do_reset();
    bpm_i = 8'd250; bpb_i = 3'd4; play_i = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      wait_beat("bar_beat", 2000, n);
      check("bar_spacing", n, 1440);
      check("bar_idx", {downbeat_o, beat_idx_o}, {1'b0, 3'(i)});
    end
    bpb_i = 3'd2;
    wait_beat("shrink_beat", 2000, n);
    check("shrink_wrap", {downbeat_o, beat_idx_o}, {1'b1, 3'd0});
    wait_beat("shrink_beat2", 2000, n);
    check("shrink_next", {downbeat_o, beat_idx_o}, {1'b0, 3'd1});
    bpb_i = 3'd0;
    wait_beat("noacc_beat", 2000, n);
    check("noaccent", {downbeat_o, beat_idx_o}, {1'b0, 3'd0});
    check_tone("tone_noaccent", 6);

    // Fractional spacing at bpm 97: ceil(k*P/97) gives 3712, 3711, 3712, 3711.
    do_reset();
    bpm_i = 8'd97; play_i = 1'b1;
    tick();
    wait_beat("frac1", 4000, n); check("frac_sp1", n, 3712);
    wait_beat("frac2", 4000, n); check("frac_sp2", n, 3711);
    wait_beat("frac3", 4000, n); check("frac_sp3", n, 3712);
    wait_beat("frac4", 4000, n); check("frac_sp4", n, 3711);

    // Tempo doubles halfway through a beat: remaining half-phase takes 750 cycles.
    do_reset();
    bpm_i = 8'd120; play_i = 1'b1;
    tick();
    for (int i = 0; i < 1500; i++) tick();
    bpm_i = 8'd240;
    wait_beat("tempo_beat", 4000, n);
    check("tempo_phase", 1500 + n, 2250);

    // Stop mid-beep truncates the tone; replay restarts at index 0.
    bpm_i = 8'd250; bpb_i = 3'd4;
    wait_beat("pre_stop", 2000, n);
    for (int i = 0; i < 50; i++) tick();
    play_i = 1'b0;
    tick();
    check("stop_mid_beep", {bell_o, beat_pulse_o, downbeat_o, beat_idx_o, running_o}, 0);
    play_i = 1'b1;
    tick();
    check("replay", {bell_o, beat_pulse_o, downbeat_o, beat_idx_o, running_o}, {1'b1, 1'b1, 1'b1, 3'd0, 1'b1});

    // Asynchronous reset in the middle of a beep.
    wait_beat("pre_rst", 2000, n);
    tick(); tick(); tick();
    check("bell_before_rst", bell_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst", {bell_o, beat_pulse_o, downbeat_o, beat_idx_o, running_o}, 0);
    tick();
    rst_i = 1'b0;
    tick();
    check("restart_after_rst", {beat_pulse_o, downbeat_o, beat_idx_o, running_o}, {1'b1, 1'b1, 3'd0, 1'b1});

    // Randomised run against a cumulative-phase model.
    do_reset();
    bpm_i = 8'd200; bpb_i = 3'd3; play_i = 1'b0;
    m_run = 1'b0; phase = 0; k = 0; m_idx = 0; last = 0; half = 6; rerr = 0;
    for (int t = 0; t < 15000 && rerr < 20; t++) begin
      r = int'($urandom_range(0, 999));
      if (r < 3) bpm_i = 8'($urandom_range(0, 255));
      else if (r < 6) bpb_i = 3'($urandom_range(0, 7));
      if (play_i) begin
        if (r == 999) play_i = 1'b0;
      end else if (r < 40 || r > 990) begin
        play_i = 1'b1;
      end
      bc = clampb(int'(bpm_i));
      bpb = int'(bpb_i);
      m_pulse = 1'b0;
      m_down = 1'b0;
      if (!m_run) begin
        if (play_i) begin
          m_run = 1'b1; phase = 0; k = 0; m_idx = 0;
          m_pulse = 1'b1; m_down = (bpb != 0); last = t; half = m_down ? 3 : 6;
        end
      end else if (!play_i) begin
        m_run = 1'b0; m_idx = 0;
      end else begin
        phase += bc;
        if (phase >= longint'(k + 1) * P) begin
          k++;
          m_idx = (m_idx + 1 >= bpb) ? 0 : m_idx + 1;
          m_pulse = 1'b1; m_down = (m_idx == 0) && (bpb != 0); last = t; half = m_down ? 3 : 6;
        end
      end
      m_bell = m_run && (t - last < 300) && ((((t - last) / half) % 2) == 0);
      tick();
      checks++;
      if ({bell_o, beat_pulse_o, downbeat_o, beat_idx_o, running_o} !==
          {m_bell, m_pulse, m_down, 3'(m_idx), m_run}) begin
        errors++;
        rerr++;
        $display("FAIL random t=%0d got bell/pulse/down/idx/run=%0b/%0b/%0b/%0d/%0b expected %0b/%0b/%0b/%0d/%0b",
                 t, bell_o, beat_pulse_o, downbeat_o, beat_idx_o, running_o,
                 m_bell, m_pulse, m_down, m_idx, m_run);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
